// File: rtl/wb_stage.sv
// Writeback stage: registers two in-order result lanes onto the RF write ports and
// backfills idle ports from a small in-order FIFO of late (multi-cycle) results.
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int LATE_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_we_a,
  input  logic [ADDR_WIDTH-1:0]         in_rd_a,
  input  logic [DATA_WIDTH-1:0]         in_data_a,
  input  logic                          in_we_b,
  input  logic [ADDR_WIDTH-1:0]         in_rd_b,
  input  logic [DATA_WIDTH-1:0]         in_data_b,
  input  logic                          late_valid,
  input  logic [ADDR_WIDTH-1:0]         late_rd,
  input  logic [DATA_WIDTH-1:0]         late_data,
  output logic                          late_ready,
  output logic                          we_a,
  output logic [ADDR_WIDTH-1:0]         waddr_a,
  output logic [DATA_WIDTH-1:0]         wdata_a,
  output logic                          we_b,
  output logic [ADDR_WIDTH-1:0]         waddr_b,
  output logic [DATA_WIDTH-1:0]         wdata_b,
  output logic [$clog2(LATE_DEPTH):0]   late_pending
);

  localparam int PTR_W = $clog2(LATE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LATE_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  logic [ADDR_WIDTH-1:0] fifo_rd   [LATE_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [LATE_DEPTH];
  logic [LATE_DEPTH-1:0] fifo_kill;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr, nxt_ptr, b_idx;
  logic [CNT_W-1:0]      count, pop_cnt, count_next;

  logic                  eff_a, eff_b, push, pop_a, pop_b, live_a, live_b, push_hit;
  logic [LATE_DEPTH-1:0] hit;
  logic                  nxt_we_a, nxt_we_b;
  logic [ADDR_WIDTH-1:0] nxt_waddr_a, nxt_waddr_b;
  logic [DATA_WIDTH-1:0] nxt_wdata_a, nxt_wdata_b;

  // Ready comes from the registered count only, so a same-edge pop gives no credit.
  assign late_ready   = (count < DEPTH_C);
  assign late_pending = count;

  always_comb begin
    eff_a   = in_we_a && (in_rd_a != '0);
    eff_b   = in_we_b && (in_rd_b != '0);
    push    = late_valid && late_ready;
    nxt_ptr = rd_ptr + PTR_W'(1);
    pop_a   = !eff_a && (count >= ONE_C);
    pop_b   = !eff_b && (count >= (pop_a ? TWO_C : ONE_C));
    b_idx   = pop_a ? nxt_ptr : rd_ptr;
    hit     = '0;
    for (int i = 0; i < LATE_DEPTH; i++) begin
      hit[i] = (eff_a && (fifo_rd[i] == in_rd_a)) || (eff_b && (fifo_rd[i] == in_rd_b));
    end
    push_hit = (eff_a && (late_rd == in_rd_a)) || (eff_b && (late_rd == in_rd_b));
    // A popped entry hit by a lane at the same edge is stale: the lane result is younger.
    live_a  = !fifo_kill[rd_ptr] && !hit[rd_ptr] && (fifo_rd[rd_ptr] != '0);
    live_b  = !fifo_kill[b_idx] && !hit[b_idx] && (fifo_rd[b_idx] != '0);
    pop_cnt    = CNT_W'(pop_a) + CNT_W'(pop_b);
    count_next = count + CNT_W'(push) - pop_cnt;

    nxt_we_a    = 1'b0;
    nxt_waddr_a = '0;
    nxt_wdata_a = '0;
    if (eff_a) begin
      nxt_we_a    = 1'b1;
      nxt_waddr_a = in_rd_a;
      nxt_wdata_a = in_data_a;
    end else if (pop_a && live_a) begin
      nxt_we_a    = 1'b1;
      nxt_waddr_a = fifo_rd[rd_ptr];
      nxt_wdata_a = fifo_data[rd_ptr];
    end

    nxt_we_b    = 1'b0;
    nxt_waddr_b = '0;
    nxt_wdata_b = '0;
    if (eff_b) begin
      nxt_we_b    = 1'b1;
      nxt_waddr_b = in_rd_b;
      nxt_wdata_b = in_data_b;
    end else if (pop_b && live_b) begin
      nxt_we_b    = 1'b1;
      nxt_waddr_b = fifo_rd[b_idx];
      nxt_wdata_b = fifo_data[b_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fifo_kill <= '0;
      for (int i = 0; i < LATE_DEPTH; i++) begin
        fifo_rd[i]   <= '0;
        fifo_data[i] <= '0;
      end
      we_a    <= 1'b0;
      waddr_a <= '0;
      wdata_a <= '0;
      we_b    <= 1'b0;
      waddr_b <= '0;
      wdata_b <= '0;
    end else begin
      fifo_kill <= fifo_kill | hit;
      if (push) begin
        fifo_rd[wr_ptr]   <= late_rd;
        fifo_data[wr_ptr] <= late_data;
        fifo_kill[wr_ptr] <= push_hit;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      rd_ptr  <= rd_ptr + pop_cnt[PTR_W-1:0];
      count   <= count_next;
      we_a    <= nxt_we_a;
      waddr_a <= nxt_waddr_a;
      wdata_a <= nxt_wdata_a;
      we_b    <= nxt_we_b;
      waddr_b <= nxt_waddr_b;
      wdata_b <= nxt_wdata_b;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, hand sequences for FIFO corners,
// and random traffic checked against a queue-based model of the writeback rules.
module tb_wb_stage;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_we_a = 0, in_we_b = 0, late_valid = 0;
  logic [AW-1:0] in_rd_a = '0, in_rd_b = '0, late_rd = '0;
  logic [DW-1:0] in_data_a = '0, in_data_b = '0, late_data = '0;
  logic          late_ready, we_a, we_b;
  logic [AW-1:0] waddr_a, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [$clog2(DEPTH):0] late_pending;

  wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_we_a(in_we_a), .in_rd_a(in_rd_a), .in_data_a(in_data_a),
    .in_we_b(in_we_b), .in_rd_b(in_rd_b), .in_data_b(in_data_b),
    .late_valid(late_valid), .late_rd(late_rd), .late_data(late_data),
    .late_ready(late_ready),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .late_pending(late_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: FIFO as a queue of {rd, data, killed}.
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    bit            kill;
  } ent_t;
  ent_t q[$];

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } port_t;

  function automatic bit lane_hit(input logic [AW-1:0] r, input bit ea, input bit eb);
    return (ea && r == in_rd_a) || (eb && r == in_rd_b);
  endfunction

  // Apply current inputs for one clock and compare every output to the model.
  task automatic cycle();
    port_t pa, pb;
    ent_t  e;
    bit    ea, eb, rdy;
    ea  = in_we_a && (in_rd_a != 0);
    eb  = in_we_b && (in_rd_b != 0);
    rdy = q.size() < DEPTH;
    pa  = '{0, '0, '0};
    pb  = '{0, '0, '0};
    if (ea) pa = '{1, in_rd_a, in_data_a};
    else if (q.size() > 0) begin
      e = q.pop_front();
      if (!e.kill && e.rd != 0 && !lane_hit(e.rd, ea, eb)) pa = '{1, e.rd, e.data};
    end
    if (eb) pb = '{1, in_rd_b, in_data_b};
    else if (q.size() > 0) begin
      e = q.pop_front();
      if (!e.kill && e.rd != 0 && !lane_hit(e.rd, ea, eb)) pb = '{1, e.rd, e.data};
    end
    foreach (q[i]) if (lane_hit(q[i].rd, ea, eb)) q[i].kill = 1;
    if (late_valid && rdy) q.push_back('{late_rd, late_data, lane_hit(late_rd, ea, eb)});
    @(posedge clk);
    #1;
    chk("m_we_a", we_a, pa.we);
    chk("m_waddr_a", waddr_a, pa.addr);
    chk("m_wdata_a", wdata_a, pa.data);
    chk("m_we_b", we_b, pb.we);
    chk("m_waddr_b", waddr_b, pb.addr);
    chk("m_wdata_b", wdata_b, pb.data);
    chk("m_pending", late_pending, q.size());
    chk("m_ready", late_ready, q.size() < DEPTH);
  endtask

  task automatic set_lanes(input bit wa, input int ra, input int da,
                           input bit wb, input int rb, input int db);
    in_we_a = wa; in_rd_a = AW'(ra); in_data_a = DW'(da);
    in_we_b = wb; in_rd_b = AW'(rb); in_data_b = DW'(db);
  endtask

  task automatic set_late(input bit v, input int r, input int d);
    late_valid = v; late_rd = AW'(r); late_data = DW'(d);
  endtask

  typedef struct {
    bit            wa; logic [AW-1:0] ra; logic [DW-1:0] da;
    bit            wb; logic [AW-1:0] rb; logic [DW-1:0] db;
    bit            xwa; logic [AW-1:0] xra; logic [DW-1:0] xda;
    bit            xwb; logic [AW-1:0] xrb; logic [DW-1:0] xdb;
  } vec_t;

  initial begin
    vec_t vecs[7];
    vecs[0] = '{1, 3, 'h11, 1, 7, 'h22,       1, 3, 'h11, 1, 7, 'h22};
    vecs[1] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 0, 'hFF, 0, 0, 0,          0, 0, 0, 0, 0, 0};
    vecs[3] = '{0, 5, 'h33, 1, 0, 'h44,       0, 0, 0, 0, 0, 0};
    vecs[4] = '{1, 31, 'hDEADBEEF, 1, 31, 'hCAFEF00D, 1, 31, 'hDEADBEEF, 1, 31, 'hCAFEF00D};
    vecs[5] = '{0, 0, 0, 1, 1, 5,             0, 0, 0, 1, 1, 5};
    vecs[6] = '{1, 2, 6, 0, 9, 7,             1, 2, 6, 0, 0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we_a", we_a, 0);
    chk("rst_we_b", we_b, 0);
    chk("rst_waddr_a", waddr_a, 0);
    chk("rst_ready", late_ready, 1);
    chk("rst_pending", late_pending, 0);
    #3 rst = 0;

    foreach (vecs[i]) begin
      set_lanes(vecs[i].wa, vecs[i].ra, vecs[i].da, vecs[i].wb, vecs[i].rb, vecs[i].db);
      cycle();
      chk($sformatf("v%0d_we_a", i), we_a, vecs[i].xwa);
      chk($sformatf("v%0d_waddr_a", i), waddr_a, vecs[i].xra);
      chk($sformatf("v%0d_wdata_a", i), wdata_a, vecs[i].xda);
      chk($sformatf("v%0d_we_b", i), we_b, vecs[i].xwb);
      chk($sformatf("v%0d_waddr_b", i), waddr_b, vecs[i].xrb);
      chk($sformatf("v%0d_wdata_b", i), wdata_b, vecs[i].xdb);
    end

    // Late result waits behind busy lanes, then fills port A
    set_lanes(1, 1, 'h101, 1, 2, 'h102);
    set_late(1, 5, 'hAB);
    cycle();
    chk("late5_pending", late_pending, 1);
    chk("late5_lane_a", waddr_a, 1);
    set_late(0, 0, 0);
    cycle();
    cycle();
    chk("late5_hold", late_pending, 1);
    set_lanes(0, 0, 0, 1, 2, 'h102);
    cycle();
    chk("late5_we_a", we_a, 1);
    chk("late5_waddr_a", waddr_a, 5);
    chk("late5_wdata_a", wdata_a, 'hAB);
    chk("late5_drained", late_pending, 0);

    // Fill FIFO, offer a third while full, then dual pop
    set_lanes(1, 1, 'h1, 1, 2, 'h2);
    set_late(1, 4, 'h44);
    cycle();
    set_late(1, 6, 'h66);
    cycle();
    chk("full_pending", late_pending, 2);
    chk("full_ready", late_ready, 0);
    set_lanes(0, 0, 0, 0, 0, 0);
    set_late(1, 8, 'h88);
    cycle();
    chk("dual_waddr_a", waddr_a, 4);
    chk("dual_wdata_a", wdata_a, 'h44);
    chk("dual_waddr_b", waddr_b, 6);
    chk("dual_wdata_b", wdata_b, 'h66);
    chk("dual_ready", late_ready, 1);
    set_late(0, 0, 0);
    cycle();
    chk("rejected_we_a", we_a, 0);

    // WAW kill of a buffered entry
    set_lanes(1, 1, 'h1, 1, 3, 'h3);
    set_late(1, 9, 'h1);
    cycle();
    set_late(0, 0, 0);
    set_lanes(1, 3, 'h3, 1, 9, 'h2);
    cycle();
    chk("kill_lane_b", wdata_b, 'h2);
    set_lanes(0, 0, 0, 0, 0, 0);
    cycle();
    chk("kill_we_a", we_a, 0);
    chk("kill_waddr_a", waddr_a, 0);
    chk("kill_pending", late_pending, 0);

    // Head popped into A at the same edge lane B overwrites it
    set_lanes(1, 1, 'h1, 1, 2, 'h2);
    set_late(1, 10, 'h10);
    cycle();
    set_late(0, 0, 0);
    set_lanes(0, 0, 0, 1, 10, 'h20);
    cycle();
    chk("same_we_a", we_a, 0);
    chk("same_waddr_b", waddr_b, 10);
    chk("same_wdata_b", wdata_b, 'h20);

    // Late entry to r0 is consumed but never written
    set_lanes(1, 1, 'h1, 1, 2, 'h2);
    set_late(1, 0, 'h77);
    cycle();
    chk("r0_pending", late_pending, 1);
    set_late(0, 0, 0);
    set_lanes(0, 0, 0, 0, 0, 0);
    cycle();
    chk("r0_we_a", we_a, 0);
    chk("r0_drained", late_pending, 0);

    // Asynchronous reset with a full FIFO and active lanes
    set_lanes(1, 1, 'h1, 1, 2, 'h2);
    set_late(1, 12, 'hC);
    cycle();
    set_late(1, 13, 'hD);
    cycle();
    chk("pre_rst_pending", late_pending, 2);
    set_late(0, 0, 0);
    #3 rst = 1;
    #1;
    chk("arst_we_a", we_a, 0);
    chk("arst_waddr_a", waddr_a, 0);
    chk("arst_wdata_a", wdata_a, 0);
    chk("arst_we_b", we_b, 0);
    chk("arst_waddr_b", waddr_b, 0);
    chk("arst_pending", late_pending, 0);
    q.delete();
    set_lanes(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #4 rst = 0;
    repeat (3) cycle();
    chk("post_rst_pending", late_pending, 0);

    // Random traffic with a narrow register range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      set_lanes($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom,
                $urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom);
      if ($urandom_range(2, 0) == 0) set_lanes(0, 0, 0, in_we_b, in_rd_b, in_data_b);
      if ($urandom_range(2, 0) == 0) set_lanes(in_we_a, in_rd_a, in_data_a, 0, 0, 0);
      set_late($urandom_range(1, 0), $urandom_range(7, 0), $urandom);
      cycle();
    end
    set_lanes(0, 0, 0, 0, 0, 0);
    set_late(0, 0, 0);
    repeat (4) cycle();
    chk("final_pending", late_pending, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
